// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with per-slot blanking, frame-aligned display latch and leading-zero blanking.
// Outputs are registered and track the slot counter after each edge; there is no backpressure, and load is a fire-and-forget strobe.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        cnt_wrap, boundary;

    logic [15:0] disp_dig, disp_dig_nxt, pend_dig, pend_dig_nxt;
    logic [3:0]  disp_dp, disp_dp_nxt, pend_dp, pend_dp_nxt;
    logic        pend_vld, pend_vld_nxt;

    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;
    logic [3:0]  nib;
    logic        lz_hide;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h40;
            4'h1: hex_decode = 7'h79;
            4'h2: hex_decode = 7'h24;
            4'h3: hex_decode = 7'h30;
            4'h4: hex_decode = 7'h19;
            4'h5: hex_decode = 7'h12;
            4'h6: hex_decode = 7'h02;
            4'h7: hex_decode = 7'h78;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h10;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h03;
            4'hC: hex_decode = 7'h46;
            4'hD: hex_decode = 7'h21;
            4'hE: hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    // State register plus all datapath/output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            disp_dig   <= 16'h0;
            disp_dp    <= 4'h0;
            pend_dig   <= 16'h0;
            pend_dp    <= 4'h0;
            pend_vld   <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            disp_dig   <= disp_dig_nxt;
            disp_dp    <= disp_dp_nxt;
            pend_dig   <= pend_dig_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_vld   <= pend_vld_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= boundary;
        end
    end

    // Next-state: counters, slot phase and the pending/display hand-off.
    always_comb begin
        cnt_wrap     = (cnt == CNT_MAX);
        cnt_nxt      = cnt_wrap ? '0 : cnt + 1'b1;
        idx_nxt      = cnt_wrap ? idx + 2'd1 : idx;
        boundary     = cnt_wrap && (idx == 2'd3);
        state_nxt    = (int'(cnt_nxt) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;

        pend_dig_nxt = load ? digits_in : pend_dig;
        pend_dp_nxt  = load ? dp_in : pend_dp;
        pend_vld_nxt = boundary ? 1'b0 : (load | pend_vld);

        disp_dig_nxt = disp_dig;
        disp_dp_nxt  = disp_dp;
        if (boundary) begin
            if (load) begin
                disp_dig_nxt = digits_in;
                disp_dp_nxt  = dp_in;
            end else if (pend_vld) begin
                disp_dig_nxt = pend_dig;
                disp_dp_nxt  = pend_dp;
            end
        end
    end

    // Output decode is taken from next-state values so the registered pins line up with cnt/idx.
    always_comb begin
        nib = disp_dig_nxt[idx_nxt*4 +: 4];
        case (idx_nxt)
            2'd3:    lz_hide = (disp_dig_nxt[15:12] == 4'h0);
            2'd2:    lz_hide = (disp_dig_nxt[15:8] == 8'h0);
            2'd1:    lz_hide = (disp_dig_nxt[15:4] == 12'h0);
            default: lz_hide = 1'b0;
        endcase
        lz_hide = lz_hide & lz_blank;

        an_nxt  = 4'b1111;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (state_nxt == ST_DRIVE) begin
            dp_nxt = ~disp_dp_nxt[idx_nxt];
            if (!lz_hide) begin
                an_nxt  = ~(4'b0001 << idx_nxt);
                seg_nxt = hex_decode(nib);
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed and random load/lz/dp stimulus against a time-indexed reference model.
module tb_display_scan_ctrl;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .lz_blank(lz_blank), .load(load), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: time since reset release decides slot and digit; frames latch pending.
    int          t = 0;
    logic [15:0] m_disp = 16'h0, m_pend = 16'h0;
    logic [3:0]  m_ddp = 4'h0, m_pdp = 4'h0;
    logic        m_pv = 1'b0, m_fd = 1'b0;
    logic [15:0] cur_d = 16'h0;
    logic [3:0]  cur_p = 4'h0;
    logic        cur_lz = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s t=%0d: observed %h expected %h", tag, t, got, want);
        end
    endtask

    task automatic step(input logic rstn, input logic ld);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int c, k;
        logic hide;
        @(negedge clk);
        rst_n = rstn; load = ld; digits_in = cur_d; dp_in = cur_p; lz_blank = cur_lz;
        @(posedge clk);
        #1;
        if (!rstn) begin
            t = 0; m_disp = 0; m_ddp = 0; m_pend = 0; m_pdp = 0; m_pv = 0; m_fd = 0;
        end else begin
            t++;
            m_fd = ((t % FRAME) == 0);
            if (m_fd) begin
                if (ld) begin m_disp = cur_d; m_ddp = cur_p; end
                else if (m_pv) begin m_disp = m_pend; m_ddp = m_pdp; end
                m_pv = 0;
            end else if (ld) begin
                m_pv = 1;
            end
            if (ld) begin m_pend = cur_d; m_pdp = cur_p; end
        end
        c = t % SD;
        k = (t / SD) % 4;
        hide = cur_lz && (k > 0) && ((m_disp >> (4 * k)) == 16'h0);
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        if (rstn && c >= BL) begin
            e_dp = ~m_ddp[k];
            if (!hide) begin
                e_an = 4'b1111 & ~(4'b0001 << k);
                e_seg = seg_tab[(m_disp >> (4 * k)) & 16'hF];
            end
        end
        check("an", {3'b0, an}, {3'b0, e_an});
        check("seg", seg, e_seg);
        check("dp", {6'b0, dp}, {6'b0, e_dp});
        check("frame_done", {6'b0, frame_done}, {6'b0, m_fd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        cur_d = d; cur_p = p;
        step(1'b1, 1'b1);
    endtask

    task automatic to_pre_boundary();
        for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0; lz_blank = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        idle(40);
        // Scan order with 0x4321
        do_load(16'h4321, 4'h0);
        idle(3 * FRAME);
        // Tear-free load during digit 1
        do_load(16'h1234, 4'h0);
        idle(2 * FRAME);
        idle(SD + 3);
        do_load(16'h5678, 4'h0);
        idle(2 * FRAME);
        // Last write wins, then load exactly on boundary
        idle(5);
        do_load(16'h1111, 4'h0);
        idle(3);
        do_load(16'h2222, 4'h0);
        idle(FRAME);
        to_pre_boundary();
        do_load(16'h9ABC, 4'h0);
        idle(FRAME);
        // Leading zeros and decimal point
        cur_lz = 1'b1;
        to_pre_boundary();
        do_load(16'h0050, 4'b0100);
        idle(2 * FRAME);
        to_pre_boundary();
        do_load(16'h0000, 4'b0000);
        idle(2 * FRAME);
        // Reset mid-scan discards pending
        idle(13);
        do_load(16'hDEF0, 4'hF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        idle(2 * FRAME);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) cur_lz = ~cur_lz;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: cur_d = 16'(($urandom_range(0, 15)) << (4 * $urandom_range(0, 3)));
                    1: cur_d = 16'h0;
                    default: cur_d = 16'($urandom);
                endcase
                cur_p = 4'($urandom);
                step(1'b1, 1'b1);
            end else if ($urandom_range(0, 499) == 0) begin
                step(1'b0, 1'b0);
            end else begin
                step(1'b1, 1'b0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
